// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and default timing constants for the gate sensor path
package parking_pkg;

  typedef enum logic [3:0] {
    IDLE,
    IN_A,
    IN_AB,
    IN_B,
    EMIT_IN,
    OUT_B,
    OUT_BA,
    OUT_A,
    EMIT_OUT
  } state_t;

  localparam int DEBOUNCE_DEF = 16;
  localparam int TIMEOUT_DEF  = 1000;
  localparam int HOLD_DEF     = 4;

  typedef logic [1:0] slot_t;

endpackage

// File: rtl/beam_debouncer.sv
// rtl/beam_debouncer.sv - 2-flop synchroniser followed by a stable-count debouncer for one IR beam
module beam_debouncer
  import parking_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The count only runs while the synced value disagrees with deb, so it never exceeds DEBOUNCE-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gate_event_encoder.sv
// rtl/gate_event_encoder.sv - turns two gate beams and a slot selector into entry/exit sensor pulses
module gate_event_encoder
  import parking_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int HOLD     = HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beam_outer,
  input  logic       beam_inner,
  input  logic [1:0] slot_sel,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] switch,
  output logic       event_busy,
  output logic       abort_pulse
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLD + 1);

  logic          o;
  logic          i;
  slot_t         slot_s1;
  slot_t         slot_s2;
  state_t        state;
  state_t        next_state;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold_cnt;
  logic          tracking;
  logic          emitting;
  logic          abort_next;

  beam_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb_outer (
    .clk (clk),
    .rst (rst),
    .raw (beam_outer),
    .deb (o)
  );

  beam_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb_inner (
    .clk (clk),
    .rst (rst),
    .raw (beam_inner),
    .deb (i)
  );

  always_comb begin
    next_state = state;
    abort_next = 1'b0;
    tracking   = state inside {IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A};
    emitting   = (state == EMIT_IN) || (state == EMIT_OUT);
    case (state)
      IDLE: begin
        if (o && !i)      next_state = IN_A;
        else if (!o && i) next_state = OUT_B;
      end
      IN_A: begin
        if (o && i) begin
          next_state = IN_AB;
        end else if (!o && !i) begin
          next_state = IDLE;
          abort_next = 1'b1;
        end
      end
      IN_AB: begin
        if (!o && i)      next_state = IN_B;
        else if (o && !i) next_state = IN_A;
      end
      IN_B: begin
        if (!o && !i)    next_state = EMIT_IN;
        else if (o && i) next_state = IN_AB;
      end
      OUT_B: begin
        if (o && i) begin
          next_state = OUT_BA;
        end else if (!o && !i) begin
          next_state = IDLE;
          abort_next = 1'b1;
        end
      end
      OUT_BA: begin
        if (o && !i)      next_state = OUT_A;
        else if (!o && i) next_state = OUT_B;
      end
      OUT_A: begin
        if (!o && !i)    next_state = EMIT_OUT;
        else if (o && i) next_state = OUT_BA;
      end
      EMIT_IN, EMIT_OUT: begin
        if (hold_cnt == HW'(HOLD - 1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // A stalled passage is abandoned even if a beam change arrives on the same cycle.
    if (tracking && timer == TW'(TIMEOUT - 1)) begin
      next_state = IDLE;
      abort_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      hold_cnt     <= '0;
      slot_s1      <= '0;
      slot_s2      <= '0;
      switch       <= '0;
      entry_sensor <= 1'b0;
      exit_sensor  <= 1'b0;
      event_busy   <= 1'b0;
      abort_pulse  <= 1'b0;
    end else begin
      state   <= next_state;
      slot_s1 <= slot_sel;
      slot_s2 <= slot_s1;
      if (next_state != state)  timer <= '0;
      else if (tracking)        timer <= timer + TW'(1);
      if (next_state != state)  hold_cnt <= '0;
      else if (emitting)        hold_cnt <= hold_cnt + HW'(1);
      if (state == IDLE && (next_state == IN_A || next_state == OUT_B)) switch <= slot_s2;
      entry_sensor <= (next_state == EMIT_IN);
      exit_sensor  <= (next_state == EMIT_OUT);
      event_busy   <= (next_state != IDLE);
      abort_pulse  <= abort_next;
    end
  end

endmodule

// File: tb/tb_gate_event_encoder.sv
// tb/tb_gate_event_encoder.sv - vector-table and directed-sequence bench for gate_event_encoder
module tb_gate_event_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       beam_outer = 1'b0;
  logic       beam_inner = 1'b0;
  logic [1:0] slot_sel = 2'd0;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [1:0] switch;
  logic       event_busy;
  logic       abort_pulse;

  gate_event_encoder #(.DEBOUNCE(4), .TIMEOUT(50), .HOLD(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .beam_outer   (beam_outer),
    .beam_inner   (beam_inner),
    .slot_sel     (slot_sel),
    .entry_sensor (entry_sensor),
    .exit_sensor  (exit_sensor),
    .switch       (switch),
    .event_busy   (event_busy),
    .abort_pulse  (abort_pulse)
  );

  always #5 clk = ~clk;

  // Raw change -> 2 sync flops -> 4 stable cycles -> registered output: 7 edges.
  localparam int LAT = 7;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   entry_hi = 0;
  int   exit_hi  = 0;
  int   abort_hi = 0;
  int   busy_hi  = 0;
  int   both_hi  = 0;
  int   last_rise = -1;
  int   abort_rise_q[$];
  logic prev_sens  = 1'b0;
  logic prev_abort = 1'b0;

  always @(negedge clk) begin
    if (entry_sensor) entry_hi++;
    if (exit_sensor) exit_hi++;
    if (abort_pulse) abort_hi++;
    if (event_busy) busy_hi++;
    if (entry_sensor && exit_sensor) both_hi++;
    if ((entry_sensor || exit_sensor) && !prev_sens) last_rise = cyc;
    if (abort_pulse && !prev_abort) abort_rise_q.push_back(cyc);
    prev_sens  = entry_sensor || exit_sensor;
    prev_abort = abort_pulse;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [0:3][1:0] ph;  // {outer, inner} per phase
    logic [1:0]      slot;
    int              exp_entry;
    int              exp_exit;
    int              exp_abort;
    logic [1:0]      exp_sw;
  } vec_t;

  localparam int NV = 6;
  vec_t vec [NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, x0, a0, b0, bz0, rel, k, q0, first, found;

    vec[0] = '{{2'b10, 2'b11, 2'b01, 2'b00}, 2'd2, 3, 0, 0, 2'd2};  // clean entry
    vec[1] = '{{2'b01, 2'b11, 2'b10, 2'b00}, 2'd1, 0, 3, 0, 2'd1};  // clean exit
    vec[2] = '{{2'b10, 2'b11, 2'b10, 2'b00}, 2'd3, 0, 0, 1, 2'd3};  // entry back-out
    vec[3] = '{{2'b01, 2'b11, 2'b01, 2'b00}, 2'd0, 0, 0, 1, 2'd0};  // exit back-out
    vec[4] = '{{2'b10, 2'b11, 2'b01, 2'b00}, 2'd3, 3, 0, 0, 2'd3};  // entry, other slot
    vec[5] = '{{2'b11, 2'b00, 2'b00, 2'b00}, 2'd1, 0, 0, 0, 2'd3};  // both at once: ignored

    rst = 1'b1;
    tick(3);
    check("rst_entry", int'(entry_sensor), 0);
    check("rst_exit", int'(exit_sensor), 0);
    check("rst_switch", int'(switch), 0);
    check("rst_busy", int'(event_busy), 0);
    check("rst_abort", int'(abort_pulse), 0);
    rst = 1'b0;
    tick(2);

    for (int v = 0; v < NV; v++) begin
      e0 = entry_hi; x0 = exit_hi; a0 = abort_hi; b0 = both_hi;
      rel = 0;
      slot_sel = vec[v].slot;
      for (int p = 0; p < 4; p++) begin
        if (p == 3) rel = cyc;
        beam_outer = vec[v].ph[p][1];
        beam_inner = vec[v].ph[p][0];
        tick(10);
      end
      tick(20);
      check($sformatf("v%0d_entry_cycles", v), entry_hi - e0, vec[v].exp_entry);
      check($sformatf("v%0d_exit_cycles", v), exit_hi - x0, vec[v].exp_exit);
      check($sformatf("v%0d_abort_cycles", v), abort_hi - a0, vec[v].exp_abort);
      check($sformatf("v%0d_switch", v), int'(switch), int'(vec[v].exp_sw));
      check($sformatf("v%0d_busy_end", v), int'(event_busy), 0);
      check($sformatf("v%0d_exclusive", v), both_hi - b0, 0);
      if (vec[v].exp_entry + vec[v].exp_exit > 0)
        check($sformatf("v%0d_latency", v), last_rise, rel + LAT);
    end

    // Bounce: outer toggles every 2 cycles, never stable long enough
    e0 = entry_hi; x0 = exit_hi; a0 = abort_hi; bz0 = busy_hi;
    for (int j = 0; j < 10; j++) begin
      beam_outer = ~beam_outer;
      tick(2);
    end
    beam_outer = 1'b0;
    tick(20);
    check("bounce_busy_cycles", busy_hi - bz0, 0);
    check("bounce_entry", entry_hi - e0, 0);
    check("bounce_exit", exit_hi - x0, 0);
    check("bounce_abort", abort_hi - a0, 0);

    // Stall: outer held 80 cycles, IN_A times out
    e0 = entry_hi; x0 = exit_hi;
    q0 = abort_rise_q.size();
    slot_sel = 2'd2;
    beam_outer = 1'b1;
    k = cyc;
    tick(80);
    beam_outer = 1'b0;
    tick(20);
    first = (abort_rise_q.size() > q0) ? abort_rise_q[q0] : -1;
    check("stall_abort_time", first, k + LAT + 50);
    check("stall_entry", entry_hi - e0, 0);
    check("stall_exit", exit_hi - x0, 0);
    check("stall_busy_end", int'(event_busy), 0);

    // Reset during the second entry_sensor cycle
    slot_sel = 2'd2;
    beam_outer = 1'b1; beam_inner = 1'b0; tick(10);
    beam_outer = 1'b1; beam_inner = 1'b1; tick(10);
    beam_outer = 1'b0; beam_inner = 1'b1; tick(10);
    beam_outer = 1'b0; beam_inner = 1'b0;
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      @(negedge clk);
      if (entry_sensor) found = 1;
    end
    check("rstemit_found", found, 1);
    @(posedge clk); #1;
    check("rstemit_2nd_cycle", int'(entry_sensor), 1);
    check("rstemit_switch_before", int'(switch), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstemit_entry", int'(entry_sensor), 0);
    check("rstemit_exit", int'(exit_sensor), 0);
    check("rstemit_switch", int'(switch), 0);
    check("rstemit_busy", int'(event_busy), 0);
    check("rstemit_abort", int'(abort_pulse), 0);
    rst = 1'b0;
    e0 = entry_hi;
    tick(10);
    check("rstemit_no_resume", entry_hi - e0, 0);
    check("rstemit_idle", int'(event_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_event_encoder.md
Name: gate_event_encoder

Overview:
- Producer side of the parking FSM's sensor interface.
- Turns two raw IR beams at the gate (outer, inner) plus a raw slot selector into clean `entry_sensor`, `exit_sensor` and `switch[1:0]` levels for the parking-system top level.
- Debounces both beams and recognises a full car passage by its beam order; partial or stalled passages emit nothing.

Parameters:
- DEBOUNCE, 16: consecutive synchronised cycles a beam must hold a new value before the debounced value changes.
- TIMEOUT, 1000: maximum cycles a passage may stay in any one tracking state before it is aborted.
- HOLD, 4: cycles `entry_sensor`/`exit_sensor` stays high per recognised event.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- beam_outer  in  1  raw outer beam, 1 = blocked, asynchronous.
- beam_inner  in  1  raw inner beam, 1 = blocked, asynchronous.
- slot_sel  in  2  raw slot selector, asynchronous, sampled at passage start.
- entry_sensor  out  1  high for HOLD cycles on a completed entry.
- exit_sensor  out  1  high for HOLD cycles on a completed exit.
- switch  out  2  slot index latched for the current or last event.
- event_busy  out  1  high whenever the FSM is not in IDLE.
- abort_pulse  out  1  one-cycle pulse when a passage is abandoned or times out.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timers 0; debounced beams 0.
- Input path:
  - Each beam passes through a 2-flop synchroniser, then a stable counter.
  - The debounced value takes the synced value once it has differed for DEBOUNCE consecutive cycles; any glitch restarts the count.
  - `slot_sel` passes through a 2-flop synchroniser only.
- Notation: O / I = debounced outer / inner.
- States and transitions:
  - IDLE: O&~I -> IN_A, latch `switch`; ~O&I -> OUT_B, latch `switch`; O&I or neither -> stay.
  - IN_A: O&I -> IN_AB; neither -> IDLE + abort_pulse.
  - IN_AB: ~O&I -> IN_B; O&~I -> IN_A.
  - IN_B: neither -> EMIT_IN; O&I -> IN_AB.
  - Exit mirror: OUT_B -> OUT_BA -> OUT_A -> EMIT_OUT, with the same back-out and reversal rules.
  - Any other O/I combination: stay in the current state.
- Timeout:
  - A timer counts in every tracking state and clears on each state change.
  - At TIMEOUT it forces IDLE and pulses abort_pulse.
- Emit states:
  - EMIT_IN / EMIT_OUT drive their sensor high for exactly HOLD cycles, then return to IDLE.
  - Beam activity during EMIT is ignored for the FSM, but debouncing continues.
  - Back-to-back events are possible, separated by at least one IDLE cycle.
- Latency: debounced final beam release -> sensor high is 1 cycle (registered output).
- Exclusivity: `entry_sensor` and `exit_sensor` are never high together.
- `switch`:
  - Changes only on IDLE -> IN_A or IDLE -> OUT_B.
  - Holds its value otherwise, including after the event, so the FSM sees it stable throughout the pulse.
- `event_busy` = (state != IDLE), registered.
- Reset mid-passage or mid-EMIT: the next cycle is IDLE with all outputs 0; no partial pulse survives.
- Width rules:
  - Debounce counter width = clog2(DEBOUNCE+1); timer width = clog2(TIMEOUT+1); hold counter width = clog2(HOLD+1).
  - No counter ever wraps; each saturates or clears.

Decomposition:
- Shared package `parking_pkg`:
  - state enum (IDLE, IN_A, IN_AB, IN_B, EMIT_IN, OUT_B, OUT_BA, OUT_A, EMIT_OUT);
  - default DEBOUNCE/TIMEOUT/HOLD constants;
  - slot index type (2 bits).
- One sub-module, `beam_debouncer` (synchroniser + stable counter, parameter DEBOUNCE), instantiated twice.

Test Plan (DEBOUNCE=4, TIMEOUT=50, HOLD=3):
- Clean entry, slot_sel=2: outer, outer+inner, inner, none, each held 10 cycles -> `entry_sensor` high exactly 3 cycles starting 1 cycle after the debounced inner release; `switch`=2; `exit_sensor` stays 0.
- Clean exit, slot_sel=1: inner, inner+outer, outer, none -> `exit_sensor` high exactly 3 cycles; `switch`=1; `entry_sensor` stays 0.
- Bounce: outer toggles every 2 cycles for 20 cycles, then held low -> debounced outer never rises; FSM stays IDLE; no outputs asserted.
- Back-out: outer, outer+inner, outer, none -> `abort_pulse` for 1 cycle; no sensor pulse; `event_busy` returns to 0.
- Stall: outer only, held 80 cycles -> `abort_pulse` 50 cycles after entering IN_A; state IDLE; no sensor pulse.
- Reset mid-EMIT: `rst` asserted in the 2nd `entry_sensor` cycle -> next cycle all outputs 0, state IDLE, `switch`=0.
